// File: rtl/mcp4725_pkg.sv
// Shared encodings for the MCP4725 waveform sequencer: modes, I2C core call codes, FSM states.
package mcp4725_pkg;

    localparam logic [1:0] MODE_LEVEL  = 2'd0;
    localparam logic [1:0] MODE_SAW    = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;
    localparam logic [1:0] MODE_SQUARE = 2'd3;

    localparam logic [1:0] CALL_WRITE = 2'b10;
    localparam logic [1:0] CALL_IDLE  = 2'b00;

    localparam logic [11:0] DAC_MAX = 12'd4095;
    localparam logic [11:0] DAC_MID = 12'd2048;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALL = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Fast-write first byte: command bits and power-down bits all zero.
    function automatic logic [7:0] dac_addr_byte(input logic [11:0] code);
        return {4'b0000, code[11:8]};
    endfunction

endpackage

// File: rtl/dac_rate_tick.sv
// Sample-rate divider: one-cycle tick every RATE_DIV clocks while enabled.
module dac_rate_tick #(
    parameter int unsigned RATE_DIV = 50000
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic iEnable,
    output logic oTick
);

    localparam int unsigned CW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(RATE_DIV - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            count_q <= '0;
        end else if (!iEnable || (count_q == LAST)) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CW'(1);
        end
    end

    // Gated so a tick cannot escape on the cycle enable drops.
    assign oTick = iEnable && (count_q == LAST);

endmodule

// File: rtl/dac_wave_sequencer.sv
// Generates DAC codes per sample tick and hands each one to the MCP4725 I2C write core.
module dac_wave_sequencer
    import mcp4725_pkg::*;
#(
    parameter int unsigned RATE_DIV = 50000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        iEnable,
    input  logic [1:0]  iMode,
    input  logic [11:0] iStep,
    input  logic [11:0] iLevel,
    output logic [1:0]  oCall,
    input  logic        iDone,
    output logic [7:0]  oAddr,
    output logic [7:0]  oData,
    output logic [11:0] oCode,
    output logic        oBusy,
    output logic        oOverrun
);

    logic        tick;
    logic [1:0]  state_q, state_d;
    logic [11:0] code_q, code_d, next_code;
    logic        down_q, down_d, next_down;
    logic        overrun_q, overrun_d;
    logic [12:0] sum;

    dac_rate_tick #(
        .RATE_DIV(RATE_DIV)
    ) u_rate_tick (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .iEnable(iEnable),
        .oTick  (tick)
    );

    assign sum = {1'b0, code_q} + {1'b0, iStep};

    // Direction falls back to up on any non-triangle sample, so entering triangle starts rising.
    always_comb begin
        next_code = code_q;
        next_down = 1'b0;
        case (iMode)
            MODE_LEVEL: next_code = iLevel;
            MODE_SAW:   next_code = sum[11:0];
            MODE_TRI: begin
                if (!down_q) begin
                    if (sum[12]) begin
                        next_code = DAC_MAX;
                        next_down = 1'b1;
                    end else begin
                        next_code = sum[11:0];
                    end
                end else if (code_q < iStep) begin
                    next_code = '0;
                end else begin
                    next_code = code_q - iStep;
                    next_down = 1'b1;
                end
            end
            MODE_SQUARE: next_code = (code_q < DAC_MID) ? DAC_MAX : '0;
            default:     next_code = code_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        down_d    = down_q;
        overrun_d = overrun_q | (tick && (state_q != ST_IDLE));
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    code_d  = next_code;
                    down_d  = next_down;
                    state_d = ST_CALL;
                end
            end
            ST_CALL: if (iDone) state_d = ST_GAP;
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            code_q    <= '0;
            down_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            down_q    <= down_d;
            overrun_q <= overrun_d;
        end
    end

    assign oCall    = (state_q == ST_CALL) ? CALL_WRITE : CALL_IDLE;
    assign oBusy    = (state_q == ST_CALL);
    assign oCode    = code_q;
    assign oAddr    = dac_addr_byte(code_q);
    assign oData    = code_q[7:0];
    assign oOverrun = overrun_q;

endmodule

// File: doc/dac_wave_sequencer.md
DAC_WAVE_SEQUENCER -- requirements
Module: dac_wave_sequencer

Interface
REQ-001 SHALL have parameter RATE_DIV, default 50000, CLOCK cycles per DAC sample (minimum 2).
REQ-002 SHALL have port CLOCK  input  1  sole clock.
REQ-003 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port iEnable  input  1  run waveform generation while high.
REQ-005 SHALL have port iMode  input  2  0 fixed level, 1 sawtooth, 2 triangle, 3 square.
REQ-006 SHALL have port iStep  input  12  code increment per sample (modes 1/2).
REQ-007 SHALL have port iLevel  input  12  code for mode 0.
REQ-008 SHALL have port oCall  output  2  request to the MCP4725 I2C core; 2'b10 = write, 2'b00 = idle.
REQ-009 SHALL have port iDone  input  1  one-cycle completion pulse from the I2C core.
REQ-010 SHALL have port oAddr  output  8  first I2C byte: {4'b0000, code[11:8]} (fast-write, PD=00).
REQ-011 SHALL have port oData  output  8  second I2C byte: code[7:0].
REQ-012 SHALL have port oCode  output  12  last code issued.
REQ-013 SHALL have port oBusy  output  1  high while a transfer is outstanding.
REQ-014 SHALL have port oOverrun  output  1  sticky: a sample tick arrived while busy.

Function
REQ-015 Tick counter SHALL count 0..RATE_DIV-1 while iEnable high, pulse tick on RATE_DIV-1, wrap to 0; held at 0 while iEnable low.
REQ-016 FSM SHALL have states IDLE, CALL, GAP.
REQ-017 IDLE: on tick, SHALL compute next code (mode sampled that cycle), register it, drive oAddr/oData from it, go CALL.
REQ-018 CALL: oCall=2'b10, oBusy=1, oAddr/oData stable; on iDone SHALL drop oCall to 2'b00 same edge and go GAP.
REQ-019 GAP: one cycle, oCall=2'b00, iDone ignored; then IDLE.
REQ-020 Tick while in CALL or GAP SHALL be dropped (no queuing) and SHALL set oOverrun until reset.
REQ-021 Mode 0: next code = iLevel.
REQ-022 Mode 1: next code = (code + iStep) mod 4096 (12-bit wrap).
REQ-023 Mode 2: up: if code+iStep > 4095 then 4095 and dir=down, else add; down: if code < iStep then 0 and dir=up, else subtract.
REQ-024 Mode 3: next code = 4095 if code < 2048 else 0.
REQ-025 iStep=0 in modes 1/2 SHALL repeat the current code (transfer still issued).
REQ-026 Entering mode 2 from any other mode SHALL start with dir=up.
REQ-027 iEnable falling during CALL SHALL let the transfer complete; no new ticks after.
REQ-028 oCode, oAddr, oData SHALL retain values while disabled.

Reset
REQ-029 RESET high SHALL immediately force: state IDLE, tick counter 0, code 0, dir up, oCall 2'b00, oAddr 0, oData 0, oCode 0, oBusy 0, oOverrun 0.
REQ-030 Reset mid-CALL SHALL abandon the transfer; the I2C core is reset by the same RESET.

Structure
REQ-031 Package mcp4725_pkg SHALL hold mode encodings, CALL_WRITE=2'b10, CALL_IDLE=2'b00, DAC_MAX=12'd4095, FSM state encodings.
REQ-032 Tick counter SHALL be sub-module dac_rate_tick (parameter RATE_DIV; ports CLOCK, RESET, iEnable, oTick).
REQ-033 Waveform arithmetic and FSM SHALL reside in dac_wave_sequencer.

Verification (RATE_DIV=4, I2C core modelled: iDone 3 cycles after oCall=2'b10)
REQ-034 Reset, iEnable=1, mode 1, iStep=12'h400 -> codes 400,800,C00,000; oAddr 04,08,0C,00; oData 00 each.
REQ-035 Mode 2, iStep=12'h700 -> codes 700,E00,FFF,8FF,1FF,000,700; dir flips at FFF and 000.
REQ-036 Mode 0, iLevel=12'hABC -> oAddr=8'h0A, oData=8'hBC; oCall held 10 until iDone, 00 exactly one following GAP cycle.
REQ-037 Model iDone delay 6 cycles -> every other tick dropped, oOverrun=1 and stays 1.
REQ-038 Mode 3 from reset -> codes FFF,000,FFF alternate per sample.
REQ-039 RESET asserted during CALL -> oCall=00, oBusy=0, oCode=0 in the same cycle; restart yields first code = iStep (mode 1).
